// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the slice-serial ALU.
//   - opcode encodings (ALU_ADD .. ALU_CP)
//   - flag bit positions within the {Z,N,H,C} flag vector
//   - FSM state type for the serial sequencer
//   - is_sub(): true for opcodes that use the subtract datapath
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_ADC = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_SBC = 3'b011;
    localparam logic [2:0] ALU_AND = 3'b100;
    localparam logic [2:0] ALU_XOR = 3'b101;
    localparam logic [2:0] ALU_OR  = 3'b110;
    localparam logic [2:0] ALU_CP  = 3'b111;

    localparam int unsigned FLAG_Z = 3;
    localparam int unsigned FLAG_N = 2;
    localparam int unsigned FLAG_H = 1;
    localparam int unsigned FLAG_C = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic is_sub(input logic [2:0] op);
        return (op == ALU_SUB) || (op == ALU_SBC) || (op == ALU_CP);
    endfunction

endpackage

// File: rtl/alu_slice.sv
// alu_slice: combinational SLICE_WIDTH-bit ALU slice.
//   op        : opcode (alu_pkg encodings)
//   a_slice   : operand A slice
//   b_slice   : operand B slice
//   cin       : raw carry into the slice adder (subtract uses A + ~B + carry)
//   res_slice : slice result
//   cout      : raw carry out of the slice adder (0 for logic ops)
module alu_slice
    import alu_pkg::*;
#(
    parameter int unsigned SLICE_WIDTH = 4
) (
    input  logic [2:0]             op,
    input  logic [SLICE_WIDTH-1:0] a_slice,
    input  logic [SLICE_WIDTH-1:0] b_slice,
    input  logic                   cin,
    output logic [SLICE_WIDTH-1:0] res_slice,
    output logic                   cout
);

    logic [SLICE_WIDTH-1:0] b_eff;
    logic [SLICE_WIDTH:0]   sum;

    always_comb begin
        b_eff = is_sub(op) ? ~b_slice : b_slice;
        sum   = {1'b0, a_slice} + {1'b0, b_eff} + {{SLICE_WIDTH{1'b0}}, cin};

        res_slice = sum[SLICE_WIDTH-1:0];
        cout      = 1'b0;
        case (op)
            ALU_AND: res_slice = a_slice & b_slice;
            ALU_XOR: res_slice = a_slice ^ b_slice;
            ALU_OR:  res_slice = a_slice | b_slice;
            default: cout      = sum[SLICE_WIDTH];
        endcase
    end

endmodule

// File: rtl/alu_serial.sv
// alu_serial: slice-serial ALU with valid/ready handshake.
// Processes a DATA_WIDTH operation in DATA_WIDTH/SLICE_WIDTH cycles, LSB
// slice first, producing Game Boy style {Z,N,H,C} flags.
//   i_clk, i_rst_n : clock (rising edge), async active-low reset
//   i_valid/o_ready: request handshake; i_control/i_data_A/i_data_B sampled
//                    on the accepting edge
//   o_valid        : one-cycle completion strobe
//   o_data/o_flags : result and {Z,N,H,C}, held until the next completion
module alu_serial
    import alu_pkg::*;
#(
    parameter int unsigned OPCODE_WIDTH = 3,
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned SLICE_WIDTH  = 4,
    parameter int unsigned HALF_BIT     = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [OPCODE_WIDTH-1:0] i_control,
    input  logic [DATA_WIDTH-1:0]   i_data_A,
    input  logic [DATA_WIDTH-1:0]   i_data_B,
    output logic                    o_valid,
    output logic [DATA_WIDTH-1:0]   o_data,
    output logic [3:0]              o_flags
);

    localparam int unsigned N_SLICES = DATA_WIDTH / SLICE_WIDTH;
    localparam int unsigned IDX_W    = (N_SLICES > 1) ? $clog2(N_SLICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SLICES - 1);
    localparam logic [IDX_W-1:0] H_IDX    = IDX_W'(HALF_BIT / SLICE_WIDTH - 1);

    if ((DATA_WIDTH % SLICE_WIDTH) != 0 || (HALF_BIT % SLICE_WIDTH) != 0 ||
        HALF_BIT == 0 || HALF_BIT >= DATA_WIDTH || OPCODE_WIDTH < 3) begin : g_bad_cfg
        $error("alu_serial: illegal parameter combination");
    end

    state_t                  state;
    logic [OPCODE_WIDTH-1:0] op_q;
    logic [DATA_WIDTH-1:0]   a_q;
    logic [DATA_WIDTH-1:0]   b_q;
    logic [DATA_WIDTH-1:0]   res_sh;
    logic [IDX_W-1:0]        idx;
    logic                    carry;
    logic                    h_q;

    logic [2:0]              op3;
    logic [SLICE_WIDTH-1:0]  a_sl;
    logic [SLICE_WIDTH-1:0]  b_sl;
    logic [SLICE_WIDTH-1:0]  slice_res;
    logic                    slice_cout;
    logic [DATA_WIDTH-1:0]   res_next;
    logic [3:0]              flags_next;
    logic                    h_raw;
    logic                    accept;
    logic                    cin_init;

    assign op3    = op_q[2:0];
    assign accept = i_valid && o_ready;
    assign a_sl   = a_q[idx*SLICE_WIDTH +: SLICE_WIDTH];
    assign b_sl   = b_q[idx*SLICE_WIDTH +: SLICE_WIDTH];

    alu_slice #(
        .SLICE_WIDTH(SLICE_WIDTH)
    ) u_slice (
        .op        (op3),
        .a_slice   (a_sl),
        .b_slice   (b_sl),
        .cin       (carry),
        .res_slice (slice_res),
        .cout      (slice_cout)
    );

    // Initial raw carry into slice 0. Subtract runs as A + ~B + ~borrow_in,
    // so SUB/CP start at 1 and SBC starts at the inverted C flag.
    always_comb begin
        cin_init = 1'b0;
        case (i_control[2:0])
            ALU_ADC: cin_init = o_flags[FLAG_C];
            ALU_SUB,
            ALU_CP:  cin_init = 1'b1;
            ALU_SBC: cin_init = ~o_flags[FLAG_C];
            default: cin_init = 1'b0;
        endcase
    end

    // Final-slice view: merge the current slice into the shadow result and
    // convert raw adder carries into borrows for the subtract family.
    always_comb begin
        res_next = res_sh;
        res_next[idx*SLICE_WIDTH +: SLICE_WIDTH] = slice_res;

        h_raw = (idx == H_IDX) ? slice_cout : h_q;

        flags_next         = '0;
        flags_next[FLAG_Z] = (res_next == '0);
        flags_next[FLAG_N] = is_sub(op3);
        case (op3)
            ALU_ADD, ALU_ADC: begin
                flags_next[FLAG_H] = h_raw;
                flags_next[FLAG_C] = slice_cout;
            end
            ALU_SUB, ALU_SBC, ALU_CP: begin
                flags_next[FLAG_H] = ~h_raw;
                flags_next[FLAG_C] = ~slice_cout;
            end
            default: begin
                flags_next[FLAG_H] = 1'b0;
                flags_next[FLAG_C] = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= ST_IDLE;
            o_valid <= 1'b0;
            o_ready <= 1'b1;
            o_data  <= '0;
            o_flags <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_sh  <= '0;
            idx     <= '0;
            carry   <= 1'b0;
            h_q     <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        op_q    <= i_control;
                        a_q     <= i_data_A;
                        b_q     <= i_data_B;
                        carry   <= cin_init;
                        idx     <= '0;
                        res_sh  <= '0;
                        h_q     <= 1'b0;
                        o_ready <= 1'b0;
                        state   <= ST_RUN;
                    end else begin
                        o_ready <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    res_sh <= res_next;
                    carry  <= slice_cout;
                    if (idx == H_IDX) begin
                        h_q <= slice_cout;
                    end
                    if (idx == LAST_IDX) begin
                        o_data  <= res_next;
                        o_flags <= flags_next;
                        o_valid <= 1'b1;
                        o_ready <= 1'b1;
                        state   <= ST_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    o_ready <= 1'b1;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
